// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the ICache, the LSB, mem_arbiter and mem_ctrl.
// The arbiter takes the slave view; the surrounding blocks (or a bench) take the master view.
interface mem_arbiter_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_data;

    logic        lsb_req;
    logic        lsb_we;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    logic        mc_req;
    logic        mc_we;
    logic [1:0]  mc_size;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport slave (
        input  ic_req, ic_addr,
        output ic_done, ic_data,
        input  lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
        output lsb_done, lsb_rdata,
        output mc_req, mc_we, mc_size, mc_addr, mc_wdata,
        input  mc_done, mc_rdata
    );

    modport master (
        output ic_req, ic_addr,
        input  ic_done, ic_data,
        output lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
        input  lsb_done, lsb_rdata,
        input  mc_req, mc_we, mc_size, mc_addr, mc_wdata,
        output mc_done, mc_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single mem_ctrl port between ICache and LSB, one transfer at a time.
// Optional IC starvation guard is compiled in with `define STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          rollback,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_LD, OWN_ST} owner_t;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        squash_q, squash_d;
    logic        mc_we_q, mc_we_d;
    logic [1:0]  mc_size_q, mc_size_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic [31:0] mc_wdata_q, mc_wdata_d;
    logic        ic_done_q, ic_done_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] ic_data_q, ic_data_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic in_idle, any_done, ic_ok, lsb_ok, force_ic;
    logic grant_ic, grant_lsb, squashable, kill;

    // The cycle a done pulses is a turnaround cycle with no grant, so the
    // earliest reissue after mc_done at D is D+3 and a held request cannot double-grant.
    assign in_idle  = (state_q == IDLE);
    assign any_done = ic_done_q | lsb_done_q;
    assign ic_ok    = bus.ic_req  & ~any_done & ~rollback;
    assign lsb_ok   = bus.lsb_req & ~any_done & ~rollback;

    assign grant_lsb = in_idle & lsb_ok & ~force_ic;
    assign grant_ic  = in_idle & ic_ok  & ~grant_lsb;

    // Stores always complete visibly; fetches and loads die with the rollback.
    assign squashable = (owner_q == OWN_IC) | (owner_q == OWN_LD);
    assign kill       = squash_q | (rollback & squashable);

`ifdef STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign force_ic = ic_ok & (starve_cnt >= CW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (rdy) begin
            if (grant_ic) begin
                starve_cnt <= '0;
            end else if (grant_lsb) begin
                if (!bus.ic_req)
                    starve_cnt <= '0;
                else if (starve_cnt < CW'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end
`else
    assign force_ic = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        squash_d    = squash_q;
        mc_we_d     = mc_we_q;
        mc_size_d   = mc_size_q;
        mc_addr_d   = mc_addr_q;
        mc_wdata_d  = mc_wdata_q;
        ic_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        ic_data_d   = ic_data_q;
        lsb_rdata_d = lsb_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_lsb) begin
                    mc_we_d    = bus.lsb_we;
                    mc_size_d  = bus.lsb_size;
                    mc_addr_d  = bus.lsb_addr;
                    mc_wdata_d = bus.lsb_wdata;
                    owner_d    = bus.lsb_we ? OWN_ST : OWN_LD;
                    state_d    = ISSUE;
                end else if (grant_ic) begin
                    mc_we_d    = 1'b0;
                    mc_size_d  = 2'd2;
                    mc_addr_d  = bus.ic_addr;
                    mc_wdata_d = 32'h0;
                    owner_d    = OWN_IC;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d  = WAIT;
                squash_d = kill;
            end
            WAIT: begin
                squash_d = kill;
                if (bus.mc_done) begin
                    state_d  = IDLE;
                    owner_d  = OWN_NONE;
                    squash_d = 1'b0;
                    if (!kill) begin
                        if (owner_q == OWN_IC) begin
                            ic_done_d = 1'b1;
                            ic_data_d = bus.mc_rdata;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = bus.mc_rdata;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            squash_q    <= 1'b0;
            mc_we_q     <= 1'b0;
            mc_size_q   <= 2'd0;
            mc_addr_q   <= 32'h0;
            mc_wdata_q  <= 32'h0;
            ic_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            ic_data_q   <= 32'h0;
            lsb_rdata_q <= 32'h0;
        end else if (rdy) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            squash_q    <= squash_d;
            mc_we_q     <= mc_we_d;
            mc_size_q   <= mc_size_d;
            mc_addr_q   <= mc_addr_d;
            mc_wdata_q  <= mc_wdata_d;
            ic_done_q   <= ic_done_d;
            lsb_done_q  <= lsb_done_d;
            ic_data_q   <= ic_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign bus.mc_req    = (state_q == ISSUE);
    assign bus.mc_we     = mc_we_q;
    assign bus.mc_size   = mc_size_q;
    assign bus.mc_addr   = mc_addr_q;
    assign bus.mc_wdata  = mc_wdata_q;
    assign bus.ic_done   = ic_done_q;
    assign bus.ic_data   = ic_data_q;
    assign bus.lsb_done  = lsb_done_q;
    assign bus.lsb_rdata = lsb_rdata_q;

endmodule
